fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write controller that shares one `fifo` write port among NUM_REQ producer blocks (GPMC register writes, SPI/UART receivers, etc.). It serialises requester words into the FIFO. It generates the edge-style single-cycle `wr_en_in` pulse with a mandatory low gap, and it holds off while the FIFO reports `full`. It sits between the producer blocks and the `fifo` instance on the FPGA side of the BeagleWire design.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, word width; equals the FIFO's BUF_DATA_WIDTH
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester write request, level
- req_data  in  NUM_REQ*DATA_W  requester words, requester i at bits [i*DATA_W +: DATA_W]
- ack  out  NUM_REQ  one-cycle pulse: requester's word has been committed to the FIFO
- grant_id  out  $clog2(NUM_REQ)  index of requester currently being served
- busy  out  1  high whenever state != IDLE
- fifo_full  in  1  FIFO `full` flag
- fifo_din  out  DATA_W  FIFO data input, registered
- fifo_wr_en_in  out  1  FIFO write strobe, registered

## Operation
- FSM states: IDLE, STROBE, GAP, SETTLE. Encoding is 2-bit binary.
- IDLE: if |req and !fifo_full:
  - pick the winner round-robin;
  - latch req_data of the winner into fifo_din;
  - set grant_id;
  - update the RR pointer to the winner;
  - go to STROBE.
- IDLE otherwise: stay in IDLE.
- STROBE: fifo_wr_en_in=1 for exactly this cycle. Go to GAP.
- GAP: fifo_wr_en_in=0. Go to SETTLE. This gap guarantees the FIFO's rising-edge detector sees every write.
- SETTLE: ack[grant_id]=1 for this cycle only. Go to IDLE. fifo_full is valid again from this cycle on.
- Round-robin rule:
  - Search starts at pointer+1 mod NUM_REQ.
  - The first asserted req wins.
  - Pointer holds the last winner.
  - Reset value of the pointer is NUM_REQ-1, so requester 0 wins first.
- Requester protocol:
  - Hold req high and req_data stable until ack.
  - Data is sampled only in the IDLE grant cycle.
  - req may stay high after ack to request the next word. New data must be presented in the cycle after ack.
- req dropped before ack: protocol violation. The write still completes and ack still pulses.
- FIFO full:
  - No grant is issued while fifo_full=1.
  - Pending requests wait indefinitely. No word is ever dropped.
  - fifo_full is not consulted after the grant is issued.
- Reset outputs: ack=0, grant_id=0, busy=0, fifo_din=0, fifo_wr_en_in=0. State returns to IDLE and the RR pointer to NUM_REQ-1.
- Reset asserted mid-transaction:
  - The in-flight word is abandoned without ack.
  - The FIFO is reset by the same rst, so its contents are consistent with the abandoned word.

## Timing
- Grant at edge E0, which ends the IDLE cycle.
- fifo_wr_en_in is high during cycle E0..E1.
- The FIFO internally detects the write at E1 and updates its counter at E2.
- ack is high during cycle E2..E3. The next grant is possible at E3.
- Throughput: 1 word per 4 clocks with continuous requests.
- Latency from req rise (FIFO not full, no contention) to ack high: 3 cycles.
- fifo_wr_en_in is never high on two consecutive cycles. It has at least 3 low cycles between pulses.
- Worst-case wait for a continuously requesting port with no full condition: (NUM_REQ-1)*4 cycles before its grant.

## Structure
- Package fifo_ctrl_pkg:
  - state localparams IDLE/STROBE/GAP/SETTLE;
  - the function clog2 used to size grant_id.
- Sub-module rr_arbiter (NUM_REQ):
  - purely combinational;
  - inputs req and pointer;
  - outputs winner index and valid.
- fifo_wr_arbiter: FSM, pointer register, data/strobe/ack registers.

## Test plan
- Single requester: req[0]=1, data 0x1234, FIFO empty.
  - fifo_wr_en_in pulses 1 cycle after grant with fifo_din=0x1234.
  - ack[0] arrives 3 cycles after req.
  - FIFO counter=1 and FIFO read returns 0x1234.
- All four requesters high continuously, data 0xA000+i.
  - Grant order is 0,1,2,3,0,…
  - One ack every 4 cycles.
  - FIFO reads back A000,A001,A002,A003 in order.
- Fill to full: requester 0 writes 32 words (BUF_WIDTH=5).
  - The 33rd request receives no grant and no ack while full=1.
  - After one FIFO read, the 33rd word is written and acked.
- Stall release: full=1 with req[2] and req[3] pending.
  - After full clears, the grant goes to the RR successor of the last winner and the other requester is served next.
- Reset mid-operation: assert rst during STROBE.
  - All outputs are 0 the same cycle (asynchronous).
  - No ack is issued.
  - After release, requester 0 has first priority.
- Strobe check: over 1000 random req cycles, fifo_wr_en_in is never high on two consecutive clocks. FIFO write count equals ack count.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write arbiter: FSM state encoding and
// the log2 helper that sizes requester index fields.
`timescale 1ns/1ps
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2,
        SETTLE = 2'd3
    } state_e;

    // Ceiling log2, never below 1 so a 2-requester index still has one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 (mod NUM_REQ) and
// returns the first asserted request.
`timescale 1ns/1ps
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [clog2(NUM_REQ)-1:0] ptr_i,
    output logic [clog2(NUM_REQ)-1:0] winner_o,
    output logic                      valid_o
);

    localparam int unsigned IDX_W = clog2(NUM_REQ);

    // ptr_i is always a legal index, so one conditional subtract wraps it.
    function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = wrap(ptr_i, k);
            if (!found && req_i[cand]) begin
                found    = 1'b1;
                winner_o = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Serialises NUM_REQ producer words onto one FIFO write port with a
// one-cycle strobe, a mandatory low gap, and a per-requester ack pulse.
`timescale 1ns/1ps
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [clog2(NUM_REQ)-1:0]   grant_id,
    output logic                        busy,
    input  logic                        fifo_full,
    output logic [DATA_W-1:0]           fifo_din,
    output logic                        fifo_wr_en_in
);

    localparam int unsigned IDX_W = clog2(NUM_REQ);

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   grant_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [DATA_W-1:0]  din_q;
    logic               wr_q;
    logic               busy_q;

    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (win_idx),
        .valid_o  (win_vld)
    );

    // Transaction sequencer; fifo_full only gates the grant, never an in-flight word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            grant_q <= '0;
            ack_q   <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            wr_q  <= 1'b0;
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_vld && !fifo_full) begin
                        state_q <= STROBE;
                        ptr_q   <= win_idx;
                        grant_q <= win_idx;
                        din_q   <= req_data[32'(win_idx) * DATA_W +: DATA_W];
                        wr_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                STROBE: state_q <= GAP;
                GAP: begin
                    state_q <= SETTLE;
                    ack_q   <= NUM_REQ'(1) << grant_q;
                end
                SETTLE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack           = ack_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign fifo_din      = din_q;
    assign fifo_wr_en_in = wr_q;

endmodule
